mini_core_pipe: RTL and testbench

- Parametrised successor to the 3-stage mini core: a 4-stage pipeline (IF, LD, EX, WB) running memory-to-memory ALU instructions.
- Widths and depths are generic; the multiply latency is configurable.
- Adds EX/WB operand forwarding, a true multi-cycle-multiply stall, an explicit start/halt lifecycle, and host load/inspect ports for instruction and data memory.
- Sits at the top of the design, driven by the testbench/host.

---
 rtl/mini_core_pipe.sv | 139 +++++++++++++
 tb/tb_mini_core_pipe.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mini_core_pipe.sv
// Four-stage (IF, LD, EX, WB) memory-to-memory ALU core with EX/WB operand
// forwarding, a multi-cycle multiply stall, a start/halt lifecycle and host memory ports.
module mini_core_pipe #(
  parameter int DW      = 8,
  parameter int AW      = 6,
  parameter int PW      = 5,
  parameter int MUL_LAT = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            im_we,
  input  logic [PW-1:0]   im_addr,
  input  logic [3*AW+1:0] im_wdata,
  input  logic            dm_we,
  input  logic [AW-1:0]   dm_addr,
  input  logic [DW-1:0]   dm_wdata,
  output logic [DW-1:0]   dm_rdata,
  output logic            running,
  output logic            halted
);
  // state    | meaning
  // S_IDLE   | out of reset, waiting for start
  // S_RUN    | pipeline fetching and executing
  // S_HALTED | HALT retired, waiting for start to rerun from PC 0
  localparam int IW = 2 + 3*AW;
  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_HALT} op_t;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} state_t;

  state_t state_q, state_d;

  logic [DW-1:0] mem [2**AW];
  logic [IW-1:0] im  [2**PW];

  logic [PW-1:0] pc_q;
  logic          if_v;
  logic [IW-1:0] if_ins;
  logic          ex_v;
  op_t           ex_op;
  logic [AW-1:0] ex_dst;
  logic [DW-1:0] ex_a, ex_b;
  logic          wb_v;
  op_t           wb_op;
  logic [AW-1:0] wb_dst;
  logic [DW-1:0] wb_data;
  logic [CW-1:0] mul_cnt;

  logic          run, mul_last, stall, halt_ex, halt_wb, fetch_en;
  logic          ex_fwd_ok, wb_fwd_ok;
  logic [DW-1:0] ex_res, opa, opb;
  op_t           ld_op;
  logic [AW-1:0] ld_s1, ld_s2, ld_dst;

  assign run      = (state_q == S_RUN);
  assign running  = run;
  assign halted   = (state_q == S_HALTED);
  assign dm_rdata = mem[dm_addr];

  assign ld_op  = op_t'(if_ins[IW-1 -: 2]);
  assign ld_s1  = if_ins[3*AW-1 -: AW];
  assign ld_s2  = if_ins[2*AW-1 -: AW];
  assign ld_dst = if_ins[AW-1:0];

  assign mul_last  = (mul_cnt == CW'(MUL_LAT-1));
  assign stall     = ex_v && (ex_op == OP_MUL) && !mul_last;
  assign halt_ex   = ex_v && (ex_op == OP_HALT);
  assign halt_wb   = wb_v && (wb_op == OP_HALT);
  assign fetch_en  = run && !stall && !halt_ex && !halt_wb;
  assign ex_fwd_ok = ex_v && ((ex_op == OP_ADD) || (ex_op == OP_SUB) ||
                              ((ex_op == OP_MUL) && mul_last));
  assign wb_fwd_ok = wb_v && (wb_op != OP_HALT);

  always_comb begin
    case (ex_op)
      OP_SUB:  ex_res = ex_a - ex_b;
      OP_MUL:  ex_res = ex_a * ex_b;
      default: ex_res = ex_a + ex_b;
    endcase
  end

  // Youngest producer wins: EX result, then the value WB is about to write.
  always_comb begin
    opa = mem[ld_s1];
    if (ex_fwd_ok && ex_dst == ld_s1)      opa = ex_res;
    else if (wb_fwd_ok && wb_dst == ld_s1) opa = wb_data;
    opb = mem[ld_s2];
    if (ex_fwd_ok && ex_dst == ld_s2)      opb = ex_res;
    else if (wb_fwd_ok && wb_dst == ld_s2) opb = wb_data;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_RUN;
      S_RUN:    if (halt_wb) state_d = S_HALTED;
      S_HALTED: if (start) state_d = S_RUN;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      pc_q    <= '0;
      if_v    <= 1'b0;
      ex_v    <= 1'b0;
      wb_v    <= 1'b0;
      mul_cnt <= '0;
    end else begin
      wb_v    <= ex_v && !stall;
      wb_op   <= ex_op;
      wb_dst  <= ex_dst;
      wb_data <= ex_res;
      mul_cnt <= stall ? mul_cnt + 1'b1 : '0;
      if (!stall) begin
        ex_v   <= if_v && !halt_ex;
        ex_op  <= ld_op;
        ex_dst <= ld_dst;
        ex_a   <= opa;
        ex_b   <= opb;
        if_v   <= fetch_en;
        if_ins <= im[pc_q];
        if (fetch_en) pc_q <= pc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && run && wb_v && wb_op != OP_HALT) mem[wb_dst] <= wb_data;
    else if (!run && dm_we)                      mem[dm_addr] <= dm_wdata;
    if (!run && im_we) im[im_addr] <= im_wdata;
  end
endmodule

// File: tb/tb_mini_core_pipe.sv
// Bench for mini_core_pipe: ISA-level sequential model plus a WB-schedule
// timing model; running/halted checked every cycle, memory swept after each run.
module tb_mini_core_pipe;
  localparam int DW = 8, AW = 6, PW = 5, L = 3;
  localparam int IW = 2 + 3*AW, NI = 1 << PW, ND = 1 << AW;
  localparam int HUGE = 1 << 28;

  logic clk = 1'b0;
  logic rst, start, im_we, dm_we;
  logic [PW-1:0] im_addr;
  logic [IW-1:0] im_wdata;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata, dm_rdata;
  logic running, halted;

  mini_core_pipe #(.DW(DW), .AW(AW), .PW(PW), .MUL_LAT(L)) dut (
    .clk(clk), .rst(rst), .start(start), .im_we(im_we), .im_addr(im_addr),
    .im_wdata(im_wdata), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .running(running), .halted(halted));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;
  logic [DW-1:0] mem_m [ND];
  logic [IW-1:0] im_m  [NI];
  int t_start = HUGE, t_len = HUGE, t_rst = 0, run_r = HUGE;
  bit prev_halted = 1'b0, chk_on = 1'b0;

  function automatic bit exp_run(input int c);
    if (c >= t_rst) return 1'b0;
    return (c >= t_start) && (c < t_start + t_len);
  endfunction

  function automatic bit exp_hlt(input int c);
    if (c >= t_rst) return 1'b0;
    if (c < t_start) return prev_halted;
    return c >= t_start + t_len;
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      checks += 2;
      if (running !== exp_run(cyc)) begin
        failures++;
        $display("FAIL running cyc=%0d got=%b exp=%b", cyc, running, exp_run(cyc));
      end
      if (halted !== exp_hlt(cyc)) begin
        failures++;
        $display("FAIL halted cyc=%0d got=%b exp=%b", cyc, halted, exp_hlt(cyc));
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  function automatic logic [IW-1:0] enc(input int op, input int s1, input int s2, input int d);
    logic [1:0] o;
    logic [AW-1:0] a, b, c;
    o = op[1:0]; a = s1[AW-1:0]; b = s2[AW-1:0]; c = d[AW-1:0];
    return {o, a, b, c};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic im_wr(input int a, input logic [IW-1:0] d);
    im_we = 1'b1; im_addr = a[PW-1:0]; im_wdata = d; im_m[a] = d;
    tick;
    im_we = 1'b0;
  endtask

  task automatic dm_wr(input int a, input int d);
    dm_we = 1'b1; dm_addr = a[AW-1:0]; dm_wdata = d[DW-1:0]; mem_m[a] = d[DW-1:0];
    tick;
    dm_we = 1'b0;
  endtask

  // Program order execution; instruction i writes at the end of cycle
  // s+4+i+(L-1)*(MULs up to and including i). Writes at or after r are lost.
  task automatic model_exec(input int s, input int r, output int len);
    int pc, muls, w;
    logic [IW-1:0] ins;
    logic [1:0] op;
    logic [AW-1:0] a, b, d;
    logic [DW-1:0] va, vb, res;
    pc = 0; muls = 0; len = HUGE;
    for (int i = 0; i < 4096; i++) begin
      ins = im_m[pc];
      op = ins[IW-1 -: 2]; a = ins[3*AW-1 -: AW]; b = ins[2*AW-1 -: AW]; d = ins[AW-1:0];
      if (op == 2'd3) begin
        len = 4 + i + (L-1)*muls;
        break;
      end
      if (op == 2'd2) muls++;
      w = s + 4 + i + (L-1)*muls;
      if (w >= r) break;
      va = mem_m[a]; vb = mem_m[b];
      case (op)
        2'd0:    res = va + vb;
        2'd1:    res = va - vb;
        default: res = va * vb;
      endcase
      mem_m[d] = res;
      pc = (pc + 1) % NI;
    end
  endtask

  task automatic do_start(input int r_rel, output int s);
    int len;
    s = cyc;
    run_r = (r_rel < 0) ? HUGE : s + r_rel;
    model_exec(s, run_r, len);
    prev_halted = exp_hlt(cyc);
    t_rst = HUGE; t_start = s + 1; t_len = len;
    start = 1'b1;
    tick;
    start = 1'b0; im_we = 1'b0; dm_we = 1'b0;
  endtask

  task automatic run_wait;
    int end_c;
    end_c = (run_r < HUGE) ? run_r : t_start + t_len;
    for (int n = 0; n < 2000 && cyc <= end_c; n++) begin
      if (cyc == run_r) begin
        rst = 1'b1;
        t_rst = run_r + 1;
      end
      tick;
      rst = 1'b0;
    end
    checks++;
    if (cyc <= end_c) begin
      failures++;
      $display("FAIL run_timeout cyc=%0d need_past=%0d", cyc, end_c);
    end
  endtask

  task automatic wait_halted(output int c);
    for (int n = 0; n < 100; n++) begin
      if (halted === 1'b1) break;
      tick;
    end
    c = cyc;
    checks++;
    if (halted !== 1'b1) begin
      failures++;
      $display("FAIL halt_timeout got=%b exp=1", halted);
    end
  endtask

  task automatic check_mem_all;
    for (int a = 0; a < ND; a++) begin
      dm_addr = a[AW-1:0];
      #1;
      checks++;
      if (dm_rdata !== mem_m[a]) begin
        failures++;
        $display("FAIL mem[%0d] got=%0d exp=%0d", a, dm_rdata, mem_m[a]);
      end
    end
  endtask

  task automatic rd(input string name, input int a, input int exp);
    dm_addr = a[AW-1:0];
    #1;
    chk(name, dm_rdata, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s, s2, c, r_rel, h, span;
    rst = 1'b1; start = 1'b0; im_we = 1'b0; dm_we = 1'b0;
    im_addr = '0; im_wdata = '0; dm_addr = '0; dm_wdata = '0;
    tick; tick;
    rst = 1'b0;
    chk_on = 1'b1;
    chk("reset_running", running, 0);
    chk("reset_halted", halted, 0);
    for (int a = 0; a < ND; a++) dm_wr(a, 0);
    for (int i = 0; i < NI; i++) im_wr(i, enc(3, 0, 0, 0));

    // basic ADD then HALT; last writes land in the start cycle
    dm_wr(1, 5);
    im_wr(0, enc(0, 1, 2, 3));
    dm_we = 1'b1; dm_addr = 6'd2; dm_wdata = 8'd7; mem_m[2] = 8'd7;
    im_we = 1'b1; im_addr = 5'd1; im_wdata = enc(3, 0, 0, 0); im_m[1] = enc(3, 0, 0, 0);
    do_start(-1, s);
    wait_halted(c);
    chk("basic_halt_cycles", c - s, 6);
    chk("basic_running", running, 0);
    rd("basic_mem3", 3, 12);
    check_mem_all;

    // back-to-back RAW, plus ignored start and blocked host write mid-run
    dm_wr(1, 3);
    dm_wr(40, 8'h11);
    im_wr(0, enc(0, 1, 1, 2));
    im_wr(1, enc(0, 2, 2, 4));
    im_wr(2, enc(1, 4, 1, 5));
    im_wr(3, enc(3, 0, 0, 0));
    do_start(-1, s);
    tick; tick;
    start = 1'b1; tick; start = 1'b0;
    dm_we = 1'b1; dm_addr = 6'd40; dm_wdata = 8'h33; tick; dm_we = 1'b0;
    wait_halted(c);
    chk("raw_halt_cycles", c - s, 8);
    rd("raw_mem2", 2, 6);
    rd("raw_mem4", 4, 12);
    rd("raw_mem5", 5, 9);
    rd("blocked_dm_we", 40, 8'h11);
    check_mem_all;

    // MUL stall: two extra cycles over the ADD-only version
    dm_wr(1, 20); dm_wr(2, 13);
    im_wr(0, enc(2, 1, 2, 3));
    im_wr(1, enc(0, 3, 1, 4));
    im_wr(2, enc(3, 0, 0, 0));
    do_start(-1, s);
    wait_halted(c);
    chk("mul_halt_cycles", c - s, 9);
    rd("mul_mem3", 3, 4);
    rd("mul_mem4", 4, 24);
    check_mem_all;

    // SUB underflow
    dm_wr(3, 3); dm_wr(4, 5);
    im_wr(0, enc(1, 3, 4, 6));
    im_wr(1, enc(3, 0, 0, 0));
    do_start(-1, s);
    wait_halted(c);
    rd("sub_wrap", 6, 254);

    // squash after HALT, then restart from HALTED
    dm_wr(9, 8'h55);
    im_wr(0, enc(3, 0, 0, 0));
    im_wr(1, enc(0, 1, 1, 9));
    do_start(-1, s);
    wait_halted(c);
    chk("squash_halt_cycles", c - s, 5);
    rd("squash_mem9", 9, 8'h55);
    do_start(-1, s2);
    chk("restart_halted_cleared", halted, 0);
    wait_halted(c);
    chk("restart_halt_cycles", c - s2, 5);
    check_mem_all;

    // PC wrap: 32-entry loop, stop by reset just after instruction 0 runs twice
    dm_wr(0, 0); dm_wr(1, 1); dm_wr(2, 0);
    im_wr(0, enc(0, 2, 1, 2));
    for (int i = 1; i < NI; i++) im_wr(i, enc(0, 0, 0, 10));
    do_start(37, s);
    run_wait;
    rd("wrap_doubled", 2, 2);
    check_mem_all;

    // reset during the second MUL cycle
    dm_wr(3, 8'h77);
    im_wr(0, enc(2, 1, 2, 3));
    im_wr(1, enc(3, 0, 0, 0));
    do_start(4, s);
    run_wait;
    chk("rstmul_running", running, 0);
    chk("rstmul_halted", halted, 0);
    rd("rstmul_mem3", 3, 8'h77);
    dm_wr(5, 8'hAB);
    rd("rstmul_host_wr", 5, 8'hAB);
    check_mem_all;

    // randomized programs, some aborted by reset
    for (int run = 0; run < 24; run++) begin
      span = (run % 2 == 0) ? 7 : ND - 1;
      for (int a = 0; a < ND; a++) dm_wr(a, int'($urandom_range(0, 255)));
      for (int i = 0; i < NI; i++)
        im_wr(i, enc(int'($urandom_range(0, 2)), int'($urandom_range(0, span)),
                     int'($urandom_range(0, span)), int'($urandom_range(0, span))));
      h = int'($urandom_range(0, 24));
      im_wr(h, enc(3, 0, 0, 0));
      r_rel = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 50)) : -1;
      do_start(r_rel, s);
      run_wait;
      check_mem_all;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
